// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load plus multi-cycle SHL/SHR/SAR/ROL shifts.
// Define USR_ROTATE_EN to enable mode 11 (ROL); otherwise a ROL start is ignored.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] shamt,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             serial_out
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef enum logic [1:0] {
    M_SHL = 2'b00,
    M_SHR = 2'b01,
    M_SAR = 2'b10,
    M_ROL = 2'b11
  } mode_t;

  state_t           state;
  state_t           state_next;
  mode_t            mode_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shamt_clamped;
  logic             mode_legal;
  logic             accept_start;
  logic [WIDTH-1:0] q_shift;
  logic             so_shift;

  always_comb begin
`ifdef USR_ROTATE_EN
    mode_legal = 1'b1;
`else
    mode_legal = (mode != 2'b11);
`endif
  end

  // A start is only honoured in IDLE (state check is applied by the users of this term).
  always_comb begin
    accept_start  = start && !load && mode_legal;
    shamt_clamped = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_start && (shamt_clamped != '0)) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == SHIFT);
  end

  // Single-bit shift of the current contents using the latched mode
  always_comb begin
    q_shift  = q;
    so_shift = serial_out;
    case (mode_r)
      M_SHL: begin
        q_shift  = {q[WIDTH-2:0], serial_in};
        so_shift = q[WIDTH-1];
      end
      M_SHR: begin
        q_shift  = {serial_in, q[WIDTH-1:1]};
        so_shift = q[0];
      end
      M_SAR: begin
        q_shift  = {q[WIDTH-1], q[WIDTH-1:1]};
        so_shift = q[0];
      end
`ifdef USR_ROTATE_EN
      M_ROL: begin
        q_shift  = {q[WIDTH-2:0], q[WIDTH-1]};
        so_shift = q[WIDTH-1];
      end
`endif
      default: begin
        q_shift  = q;
        so_shift = serial_out;
      end
    endcase
  end

  // Datapath: contents, serial output, count, latched mode and done pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q          <= '0;
      serial_out <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      mode_r     <= M_SHL;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            q <= d;
          end else if (accept_start) begin
            mode_r <= mode_t'(mode);
            cnt    <= shamt_clamped;
            // Zero-length operation completes immediately without entering SHIFT
            if (shamt_clamped == '0) begin
              done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          q          <= q_shift;
          serial_out <= so_shift;
          cnt        <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
